// File: rtl/keypad_emulator_if.sv
// Command/status bundle between a test controller and the keypad emulator.
interface keypad_emulator_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] hold_cycles;
  logic        key_ready;
  logic        busy;
  logic        contact;
  logic [7:0]  presses_done;

  modport master (
    output key_valid, key_code, hold_cycles,
    input  key_ready, busy, contact, presses_done
  );

  modport slave (
    input  key_valid, key_code, hold_cycles,
    output key_ready, busy, contact, presses_done
  );
endinterface

// File: rtl/keypad_emulator.sv
// Emulates a 4x4 key matrix with one programmable key; answers the scanner's LINE drive on COLLUMMN.
// Optional contact bounce phases are compiled in when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_emulator #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned BOUNCE_PERIOD  = 2,
  parameter int unsigned BOUNCE_TOGGLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] LINE,
  output logic [3:0] COLLUMMN,
  keypad_emulator_if.slave kp
);

`ifdef KEYPAD_EMU_BOUNCE_EN
  typedef enum logic [2:0] {IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE, GAP} state_t;
  localparam int unsigned TW       = $clog2(BOUNCE_TOGGLES + 1);
  localparam logic [15:0] PER_LAST = 16'(BOUNCE_PERIOD - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(BOUNCE_TOGGLES);
  logic [TW-1:0] tog_q, tog_d;
`else
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  code_q, code_d;
  logic        contact_q, contact_d;
  logic [7:0]  presses_q, presses_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      code_q    <= '0;
      contact_q <= 1'b0;
      presses_q <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      code_q    <= code_d;
      contact_q <= contact_d;
      presses_q <= presses_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_q     <= tog_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    code_d    = code_q;
    contact_d = contact_q;
    presses_d = presses_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    tog_d     = tog_q;
`endif
    case (state_q)
      IDLE: begin
        if (kp.key_valid) begin
          code_d    = kp.key_code;
          hold_d    = (kp.hold_cycles == 16'd0) ? 16'd1 : kp.hold_cycles;
          cnt_d     = '0;
          contact_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
          tog_d     = '0;
          state_d   = BOUNCE_PRESS;
`else
          state_d   = HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      // After the last toggle the contact rests one more period before the phase ends.
      BOUNCE_PRESS, BOUNCE_RELEASE: begin
        if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          if (tog_q == TOG_LAST) begin
            state_d = (state_q == BOUNCE_PRESS) ? HOLD : GAP;
          end else begin
            contact_d = ~contact_q;
            tog_d     = tog_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      HOLD: begin
        if (cnt_q == hold_q - 16'd1) begin
          cnt_d     = '0;
          contact_d = 1'b0;
          presses_d = presses_q + 8'd1;
`ifdef KEYPAD_EMU_BOUNCE_EN
          tog_d     = '0;
          state_d   = BOUNCE_RELEASE;
`else
          state_d   = GAP;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    COLLUMMN = '1;
    if (contact_q && !LINE[code_q[3:2]]) COLLUMMN[code_q[1:0]] = 1'b0;
  end

  assign kp.key_ready    = (state_q == IDLE);
  assign kp.busy         = (state_q != IDLE);
  assign kp.contact      = contact_q;
  assign kp.presses_done = presses_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: each accepted press queues its per-cycle expected trace.
module tb_keypad_emulator;
  localparam int unsigned G = 16;
  localparam int unsigned P = 2;
  localparam int unsigned T = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int unsigned BOUNCE_LEN = (T + 1) * P;
`else
  localparam int unsigned BOUNCE_LEN = 0;
`endif

  typedef struct {
    bit         c;
    logic [1:0] row;
    logic [1:0] col;
    logic [7:0] pd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] LINE = 4'hF;
  logic [3:0] COLLUMMN;
  keypad_emulator_if kif();

  exp_t sbq[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [7:0] exp_pd = '0;
  int unsigned line_mode = 0;   // 0 held, 1 rotating scan, 2 random
  logic [3:0]  line_hold = 4'hF;
  int unsigned rot = 0;

  keypad_emulator #(.GAP_CYCLES(G), .BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(T)) dut (
    .clk(clk), .rst(rst), .LINE(LINE), .COLLUMMN(COLLUMMN), .kp(kif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected contact level per busy cycle, built from the phase lengths.
  task automatic push_trace(input logic [3:0] code, input logic [15:0] hold);
    int unsigned h;
    exp_t e;
    h = (hold == 16'd0) ? 1 : int'(hold);
    e.row = code[3:2];
    e.col = code[1:0];
    e.pd  = exp_pd;
    for (int unsigned k = 0; k < BOUNCE_LEN; k++) begin
      e.c = ((k / P) % 2) == 0;
      sbq.push_back(e);
    end
    e.c = 1'b1;
    for (int unsigned k = 0; k < h; k++) sbq.push_back(e);
    exp_pd = exp_pd + 8'd1;
    e.pd = exp_pd;
    for (int unsigned k = 0; k < BOUNCE_LEN; k++) begin
      e.c = ((k / P) % 2) == 1;
      sbq.push_back(e);
    end
    e.c = 1'b0;
    for (int unsigned k = 0; k < G; k++) sbq.push_back(e);
  endtask

  task automatic press(input logic [3:0] code, input logic [15:0] hold, input bit glitch);
    int unsigned n = 0;
    @(negedge clk);
    while (!kif.key_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!kif.key_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: key_ready still 0 after %0d cycles, required 1", n);
      return;
    end
    kif.key_valid   = 1'b1;
    kif.key_code    = code;
    kif.hold_cycles = hold;
    @(posedge clk);
    push_trace(code, hold);
    @(negedge clk);
    kif.key_valid   = 1'b0;
    kif.key_code    = 4'($urandom);
    kif.hold_cycles = 16'($urandom);
    if (glitch) begin
      repeat (BOUNCE_LEN) @(negedge clk);
      kif.key_valid   = 1'b1;
      kif.key_code    = ~code;
      kif.hold_cycles = 16'd3;
      repeat (3) @(negedge clk);
      kif.key_valid   = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (kif.busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (kif.busy) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: busy still 1, required 0");
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (line_mode)
      0: LINE = line_hold;
      1: begin
        LINE = ~(4'b0001 << (rot % 4));
        rot++;
      end
      default: LINE = 4'($urandom);
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] ec;
    if (!rst) begin
      chk("ready_inv_busy", kif.key_ready, !kif.busy);
      if (kif.busy) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_busy: busy=1, required 0 (no press pending)");
        end else begin
          e = sbq.pop_front();
          ec = 4'hF;
          if (e.c && !LINE[e.row]) ec[e.col] = 1'b0;
          chk("contact", kif.contact, e.c);
          chk("collummn", COLLUMMN, ec);
          chk("presses_done", kif.presses_done, e.pd);
        end
      end else begin
        if (sbq.size() != 0) begin
          n_chk++; n_fail++;
          $display("FAIL early_idle: busy=0 with %0d expected cycles left, required busy=1", sbq.size());
          sbq.delete();
        end
        chk("idle_collummn", COLLUMMN, 4'hF);
        chk("idle_contact", kif.contact, 1'b0);
        chk("idle_presses", kif.presses_done, exp_pd);
      end
    end
  end

  initial begin
    kif.key_valid   = 1'b0;
    kif.key_code    = '0;
    kif.hold_cycles = '0;
    #3;
    chk("rst_collummn", COLLUMMN, 4'hF);
    chk("rst_ready", kif.key_ready, 1'b1);
    chk("rst_busy", kif.busy, 1'b0);
    chk("rst_contact", kif.contact, 1'b0);
    chk("rst_presses", kif.presses_done, 8'd0);
    #14 rst = 1'b0;

    line_mode = 0; line_hold = 4'b1101;
    press(4'd6, 16'd10, 1'b0);
    line_mode = 1;
    press(4'd6, 16'd10, 1'b0);
    line_mode = 0; line_hold = 4'b0111;
    press(4'd15, 16'd5, 1'b0);
    line_mode = 0; line_hold = 4'b1011;
    press(4'd9, 16'd0, 1'b0);
    line_mode = 0; line_hold = 4'b1111;
    press(4'd5, 16'd6, 1'b0);
    line_mode = 0; line_hold = 4'b1110;
    press(4'd1, 16'd10, 1'b1);

    press(4'd3, 16'd30, 1'b0);
    repeat (BOUNCE_LEN + 4) @(negedge clk);
    chk("pre_rst_contact", kif.contact, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_collummn", COLLUMMN, 4'hF);
    chk("midrst_presses", kif.presses_done, 8'd0);
    chk("midrst_ready", kif.key_ready, 1'b1);
    chk("midrst_contact", kif.contact, 1'b0);
    sbq.delete();
    exp_pd = '0;
    #1 rst = 1'b0;

    line_mode = 2;
    for (int i = 0; i < 256; i++) press(4'($urandom), 16'd1, 1'b0);
    wait_idle();
    chk("wrap_presses", kif.presses_done, 8'd0);

    for (int i = 0; i < 30; i++) begin
      press(4'($urandom), 16'($urandom_range(0, 12)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 16'(sbq.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- GAP_CYCLES, 16, idle cycles enforced after each release before the next key is accepted (>=1).
- BOUNCE_PERIOD, 2, cycles between contact toggles during a bounce phase (>=1).
- BOUNCE_TOGGLES, 4, contact toggles per bounce phase (even, >=2).
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- LINE, in, 4, row drive from the keypad scanner; active-low, normally one row low at a time.
- COLLUMMN, out, 4, column sense returned to the scanner; active-low, idle 4'b1111.
- key_valid, in, 1, key-press command request.
- key_code, in, 4, matrix position: row = key_code[3:2], column = key_code[1:0].
- hold_cycles, in, 16, stable-contact duration in cycles; 0 is treated as 1.
- key_ready, out, 1, high only in IDLE; a command is accepted on a clk edge where key_valid && key_ready.
- busy, out, 1, the inverse of key_ready.
- contact, out, 1, registered emulated switch closure.
- presses_done, out, 8, count of completed presses; wraps from 255 to 0.

Function
REQ-003 Block role: it is the responder end of the keypad scan interface and behaves as a physical 4x4 matrix with one programmable key.
REQ-004 Column output rule: COLLUMMN[c] = 0 iff contact=1, c = latched column, and LINE[latched row] = 0; all other bits are 1.
REQ-005 The LINE-to-COLLUMMN path is purely combinational, with zero-cycle latency. The other LINE bits do not affect the result.
REQ-006 States: IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE, GAP.
REQ-007 On the accept edge the block latches key_code and max(hold_cycles,1), then moves to BOUNCE_PRESS with contact=1.
REQ-008 BOUNCE_PRESS: contact toggles every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times, and ends at 1. The block then enters HOLD.
REQ-009 HOLD: contact=1 for exactly the latched hold count. The block then enters BOUNCE_RELEASE with contact=0.
REQ-010 BOUNCE_RELEASE: contact toggles every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times, and ends at 0. The block then enters GAP.
REQ-011 presses_done increments by 1 on the HOLD exit edge.
REQ-012 GAP: contact=0 for GAP_CYCLES cycles, then IDLE.
REQ-013 key_valid asserted while key_ready=0 is ignored and not queued. key_code and hold_cycles changing after acceptance have no effect.
REQ-014 LINE=4'b1111 yields COLLUMMN=4'b1111 in every state.

Reset
REQ-015 While rst=1, immediately and independent of clk, the block forces:
- state = IDLE
- contact = 0
- COLLUMMN = 4'b1111
- key_ready = 1
- busy = 0
- presses_done = 0
- all counters and latches cleared
REQ-016 A reset asserted mid-press aborts the press with no increment. The first edge after rst falls may accept a command.

Configuration
REQ-017 Macro: KEYPAD_EMU_BOUNCE_EN.
- Defined: the bounce phases behave per REQ-008 and REQ-010.
- Undefined: BOUNCE_PRESS and BOUNCE_RELEASE are not compiled. Accept goes directly to HOLD (contact=1 the cycle after accept); HOLD goes directly to GAP. BOUNCE_PERIOD and BOUNCE_TOGGLES are unused.

Verification
REQ-018 The bench SHALL cover these directed scenarios.
- No bounce, key_code=6, hold_cycles=10, LINE=4'b1101 held -> COLLUMMN=4'b1011 for exactly 10 cycles, then 4'b1111; presses_done=1.
- Same press with a rotating scan LINE 1110/1101/1011/0111 -> only the 1101 slots return 1011; every other slot returns 1111.
- Bounce enabled, defaults, key_code=15, hold_cycles=5, LINE=4'b0111 -> COLLUMMN[3]/contact trace: press 1,1,0,0,1,1,0,0,1,1; hold 1 x5; release 0,0,1,1,0,0,1,1,0,0; then 16 idle cycles before key_ready=1.
- hold_cycles=0 -> contact held for 1 cycle.
- key_valid pulsed during HOLD with a different code -> ignored; presses_done increments once.
- rst pulsed mid-HOLD -> COLLUMMN=4'b1111 and presses_done=0 before the next clk edge; key_ready=1.
- 256 back-to-back presses -> presses_done wraps to 0.
